// File: rtl/qos_req_issuer_pkg.sv
// Shared definitions for the QoS request issuer and the entry arbiter it feeds.
// Holds the QoS tag width, the top QoS class and the credit-counter width helper.
package qos_req_issuer_pkg;

  localparam int unsigned QOS_W = 4;
  localparam logic [QOS_W-1:0] QOS_MAX = '1;

  // The counter must be able to hold ENTRY_NUM itself, not just ENTRY_NUM-1.
  function automatic int unsigned cred_w(input int unsigned entry_num);
    return $clog2(entry_num) + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_STALL,
    ST_PRESENT
  } issue_state_e;

endpackage

// File: rtl/qos_req_issuer_if.sv
// Upstream request port, arbiter-facing request port and credit signals of the issuer.
// The master side is the issuer itself; the slave side is the source/arbiter environment.
interface qos_req_issuer_if #(
  parameter int unsigned ENTRY_NUM = 32,
  parameter int unsigned QOS_W     = 4,
  parameter int unsigned PAYLOAD_W = 32
);
  import qos_req_issuer_pkg::*;

  localparam int unsigned CW = cred_w(ENTRY_NUM);

  logic                 src_vld;
  logic                 src_rdy;
  logic [QOS_W-1:0]     src_qos;
  logic [PAYLOAD_W-1:0] src_payload;
  logic                 tx_vld;
  logic                 tx_rdy;
  logic [QOS_W-1:0]     tx_qos;
  logic [PAYLOAD_W-1:0] tx_payload;
  logic                 cred_ret;
  logic [CW-1:0]        credits;
  logic                 cred_err;

  modport master (
    input  src_vld, src_qos, src_payload, tx_rdy, cred_ret,
    output src_rdy, tx_vld, tx_qos, tx_payload, credits, cred_err
  );

  modport slave (
    output src_vld, src_qos, src_payload, tx_rdy, cred_ret,
    input  src_rdy, tx_vld, tx_qos, tx_payload, credits, cred_err
  );

endinterface

// File: rtl/qos_req_issuer_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count and combinational head read.
// Storage is cleared on reset so the head reads zero while empty after reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qos_req_issuer.sv
// Credit-gated request issuer: buffers QoS-tagged requests and presents them to the arbiter,
// promoting a request to the top QoS class if it has starved for credits long enough.
module qos_req_issuer #(
  parameter int unsigned ENTRY_NUM     = 32,
  parameter int unsigned QOS_W         = 4,
  parameter int unsigned PAYLOAD_W     = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STARVE_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  qos_req_issuer_if.master bus
);
  import qos_req_issuer_pkg::*;

  localparam int unsigned CW   = cred_w(ENTRY_NUM);
  localparam int unsigned AGEW = $clog2(STARVE_CYCLES) + 1;
  localparam int unsigned DW   = QOS_W + PAYLOAD_W;

  logic [DW-1:0]   head_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [CW-1:0]   credits;
  logic            cred_err;
  logic [AGEW-1:0] age;
  logic            promote;
  issue_state_e    state;

  assign push = bus.src_vld && !fifo_full;
  assign pop  = bus.tx_rdy && (state == ST_PRESENT);

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({bus.src_qos, bus.src_payload}),
    .pop       (pop),
    .head      (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Presentation state is fully implied by FIFO occupancy and the credit count.
  always_comb begin
    state = ST_EMPTY;
    if (!fifo_empty) begin
      state = (credits == '0) ? ST_STALL : ST_PRESENT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits  <= CW'(ENTRY_NUM);
      cred_err <= 1'b0;
    end else begin
      case ({pop, bus.cred_ret})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits != CW'(ENTRY_NUM)) begin
            credits <= credits + CW'(1);
          end
        end
        default: credits <= credits;
      endcase
      if (bus.cred_ret && (credits == CW'(ENTRY_NUM))) begin
        cred_err <= 1'b1;
      end
    end
  end

  // Age only advances while stalled, so tx_qos cannot change under a raised tx_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (pop) begin
      age <= '0;
    end else if ((state == ST_STALL) && (age != AGEW'(STARVE_CYCLES))) begin
      age <= age + AGEW'(1);
    end
  end

  assign promote = (age == AGEW'(STARVE_CYCLES));

  always_comb begin
    bus.src_rdy    = !fifo_full;
    bus.tx_vld     = (state == ST_PRESENT);
    bus.tx_payload = head_data[PAYLOAD_W-1:0];
    bus.tx_qos     = promote ? '1 : head_data[DW-1 -: QOS_W];
    bus.credits    = credits;
    bus.cred_err   = cred_err;
  end

endmodule

// File: tb/tb_qos_req_issuer.sv
// Directed bench for qos_req_issuer with a scoreboard of expected presentations.
module tb_qos_req_issuer;
  import qos_req_issuer_pkg::*;

  localparam int unsigned ENTRY_NUM = 32;
  localparam int unsigned QW        = 4;
  localparam int unsigned PW        = 32;
  localparam int unsigned CW        = cred_w(ENTRY_NUM);

  typedef struct packed {
    logic [QW-1:0] qos;
    logic [PW-1:0] payload;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  qos_req_issuer_if #(.ENTRY_NUM(ENTRY_NUM), .QOS_W(QW), .PAYLOAD_W(PW)) bus ();

  qos_req_issuer #(
    .ENTRY_NUM     (ENTRY_NUM),
    .QOS_W         (QW),
    .PAYLOAD_W     (PW),
    .FIFO_DEPTH    (4),
    .STARVE_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Every handshake the arbiter would see is matched against the scoreboard.
  always @(negedge clk) begin
    req_t e;
    if (rst_n && bus.tx_vld === 1'b1 && bus.tx_rdy === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $error("FAIL unexpected_tx observed qos=%0h payload=%0h required=no request", bus.tx_qos, bus.tx_payload);
      end else begin
        e = sb.pop_front();
        assert (bus.tx_qos === e.qos && bus.tx_payload === e.payload) else begin
          failures++;
          $error("FAIL tx_req observed qos=%0h payload=%0h required qos=%0h payload=%0h",
                 bus.tx_qos, bus.tx_payload, e.qos, e.payload);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push_one(input logic [QW-1:0] q, input logic [PW-1:0] p, input bit promoted);
    req_t r;
    bus.src_vld     = 1'b1;
    bus.src_qos     = q;
    bus.src_payload = p;
    r.qos     = promoted ? QOS_MAX : q;
    r.payload = p;
    sb.push_back(r);
    tick();
    bus.src_vld = 1'b0;
  endtask

  task automatic drain(input int unsigned bound);
    for (int unsigned i = 0; i < bound; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic stream(input int unsigned n, input logic [PW-1:0] base);
    bus.tx_rdy = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      push_one(QW'(i % 16), base + PW'(i), 1'b0);
    end
    drain(8);
  endtask

  initial begin
    bus.src_vld = 1'b0;
    bus.src_qos = '0;
    bus.src_payload = '0;
    bus.tx_rdy = 1'b0;
    bus.cred_ret = 1'b0;

    // Reset values
    repeat (2) neg();
    chk("rst_src_rdy", 64'(bus.src_rdy), 64'd1);
    chk("rst_tx_vld", 64'(bus.tx_vld), 64'd0);
    chk("rst_tx_qos", 64'(bus.tx_qos), 64'd0);
    chk("rst_tx_payload", 64'(bus.tx_payload), 64'd0);
    chk("rst_credits", 64'(bus.credits), 64'd32);
    chk("rst_cred_err", 64'(bus.cred_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request: one-cycle latency, credit consumed on accept
    push_one(4'd3, 32'hA5, 1'b0);
    neg();
    chk("first_tx_vld", 64'(bus.tx_vld), 64'd1);
    chk("first_tx_qos", 64'(bus.tx_qos), 64'd3);
    chk("first_tx_payload", 64'(bus.tx_payload), 64'hA5);
    chk("first_credits_pre", 64'(bus.credits), 64'd32);
    bus.tx_rdy = 1'b1;
    tick();
    bus.tx_rdy = 1'b0;
    neg();
    chk("first_credits_post", 64'(bus.credits), 64'd31);
    chk("first_tx_vld_post", 64'(bus.tx_vld), 64'd0);

    // Fill the FIFO with the arbiter stalled
    for (int unsigned i = 1; i <= 4; i++) begin
      push_one(QW'(i), 32'h100 + PW'(i), 1'b0);
    end
    neg();
    chk("full_src_rdy", 64'(bus.src_rdy), 64'd0);
    chk("full_head", 64'(bus.tx_payload), 64'h101);
    bus.src_vld = 1'b1;
    bus.src_qos = 4'd9;
    bus.src_payload = 32'hDEAD;
    tick();
    tick();
    bus.src_vld = 1'b0;
    neg();
    chk("full_hold_src_rdy", 64'(bus.src_rdy), 64'd0);
    chk("full_hold_head", 64'(bus.tx_payload), 64'h101);
    bus.tx_rdy = 1'b1;
    tick();
    neg();
    chk("after_pop_src_rdy", 64'(bus.src_rdy), 64'd1);
    repeat (3) tick();
    bus.tx_rdy = 1'b0;
    neg();
    chk("fill_drained_vld", 64'(bus.tx_vld), 64'd0);
    chk("fill_credits", 64'(bus.credits), 64'd27);
    chk("fill_sb_empty", 64'(sb.size()), 64'd0);

    // Back-to-back streaming down to 5 credits
    stream(22, 32'h2000);
    neg();
    chk("stream_credits", 64'(bus.credits), 64'd5);

    // Same-cycle credit return and handshake
    bus.tx_rdy = 1'b0;
    push_one(4'd7, 32'h777, 1'b0);
    neg();
    chk("same_cycle_vld", 64'(bus.tx_vld), 64'd1);
    tick();
    bus.tx_rdy = 1'b1;
    bus.cred_ret = 1'b1;
    tick();
    bus.cred_ret = 1'b0;
    neg();
    chk("same_cycle_credits", 64'(bus.credits), 64'd5);

    // Exhaust credits, starve a request, then return one credit
    stream(5, 32'h3000);
    neg();
    chk("exhaust_credits", 64'(bus.credits), 64'd0);
    push_one(4'd2, 32'h5555, 1'b1);
    neg();
    chk("stall_tx_vld", 64'(bus.tx_vld), 64'd0);
    repeat (20) tick();
    neg();
    chk("stall_long_tx_vld", 64'(bus.tx_vld), 64'd0);
    bus.cred_ret = 1'b1;
    tick();
    bus.cred_ret = 1'b0;
    neg();
    chk("promote_tx_vld", 64'(bus.tx_vld), 64'd1);
    chk("promote_tx_qos", 64'(bus.tx_qos), 64'hF);
    chk("promote_credits", 64'(bus.credits), 64'd1);
    tick();
    neg();
    chk("promote_credits_post", 64'(bus.credits), 64'd0);
    chk("promote_sb_empty", 64'(sb.size()), 64'd0);

    // Return every credit, then one too many
    for (int unsigned i = 0; i < 32; i++) begin
      bus.cred_ret = 1'b1;
      tick();
    end
    bus.cred_ret = 1'b0;
    neg();
    chk("refill_credits", 64'(bus.credits), 64'd32);
    chk("refill_cred_err", 64'(bus.cred_err), 64'd0);
    bus.cred_ret = 1'b1;
    tick();
    bus.cred_ret = 1'b0;
    neg();
    chk("over_credits", 64'(bus.credits), 64'd32);
    chk("over_cred_err", 64'(bus.cred_err), 64'd1);
    repeat (5) tick();
    neg();
    chk("over_cred_err_sticky", 64'(bus.cred_err), 64'd1);

    // Asynchronous reset mid-stream
    stream(22, 32'h4000);
    bus.tx_rdy = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      push_one(4'd5, 32'h600 + PW'(i), 1'b0);
    end
    neg();
    chk("pre_rst_tx_vld", 64'(bus.tx_vld), 64'd1);
    chk("pre_rst_credits", 64'(bus.credits), 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_vld", 64'(bus.tx_vld), 64'd0);
    chk("mid_rst_credits", 64'(bus.credits), 64'd32);
    chk("mid_rst_src_rdy", 64'(bus.src_rdy), 64'd1);
    chk("mid_rst_cred_err", 64'(bus.cred_err), 64'd0);
    chk("mid_rst_tx_payload", 64'(bus.tx_payload), 64'd0);
    sb.delete();
    tick();
    neg();
    rst_n = 1'b1;
    bus.tx_rdy = 1'b1;
    repeat (6) tick();
    neg();
    chk("post_rst_tx_vld", 64'(bus.tx_vld), 64'd0);
    chk("post_rst_credits", 64'(bus.credits), 64'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qos_req_issuer.md
# qos_req_issuer

Producer-side issuer that feeds QoS-tagged requests into the shared QoS/timeout entry arbiter. It buffers upstream requests in a small FIFO and presents them on a valid/ready port, gated by a credit counter that mirrors free arbiter entries. Requests stalled too long for lack of credits are promoted to the highest QoS class before presentation. It sits between a request source (DMA/PE command port) and the arbiter's input handshake.

## Interface
- ENTRY_NUM, 32, arbiter entry count = initial credits
- QOS_W, 4, QoS tag width
- PAYLOAD_W, 32, request payload width
- FIFO_DEPTH, 4, pending-request buffer depth (power of 2, ≥2)
- STARVE_CYCLES, 16, credit-stall cycles before QoS promotion (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_vld  in  1  upstream request valid
- src_rdy  out  1  upstream ready (FIFO not full)
- src_qos  in  QOS_W  upstream QoS class
- src_payload  in  PAYLOAD_W  upstream payload
- tx_vld  out  1  request valid to arbiter
- tx_rdy  in  1  arbiter ready
- tx_qos  out  QOS_W  presented QoS (possibly promoted)
- tx_payload  out  PAYLOAD_W  presented payload
- cred_ret  in  1  one-cycle pulse: one arbiter entry freed
- credits  out  $clog2(ENTRY_NUM)+1  current credit count
- cred_err  out  1  sticky: credit return while credits == ENTRY_NUM

## Operation
- FIFO holds {qos, payload}; push on src_vld&src_rdy; pop on tx_vld&tx_rdy.
- src_rdy = !full, derived from registered count only (no same-cycle pop-through when full).
- tx_vld = !empty && credits != 0. tx_payload/tx_qos reflect FIFO head.
- Credits: reset to ENTRY_NUM; −1 on tx handshake; +1 on cred_ret; both same cycle → unchanged.
- cred_ret at credits == ENTRY_NUM: credits stay ENTRY_NUM, cred_err set; cleared only by reset.
- Aging: age counter (width $clog2(STARVE_CYCLES)+1) increments each cycle head is present (!empty) and credits == 0; saturates at STARVE_CYCLES; clears on pop and on reset.
- promote = (age == STARVE_CYCLES); tx_qos = promote ? all-ones : head qos. Since age only advances while tx_vld is low, tx_qos never changes while tx_vld is high.
- Once tx_vld rises, tx_vld/tx_qos/tx_payload are stable until handshake (credits can only rise while waiting, and the head is fixed).
- States (implicit): EMPTY (!empty=0), STALL (head, credits 0, aging), PRESENT (tx_vld=1). EMPTY→STALL/PRESENT on push; STALL→PRESENT on cred_ret; PRESENT→EMPTY/STALL/PRESENT on pop depending on remaining entries/credits.

## Timing
- Reset values: src_rdy=1, tx_vld=0, tx_qos=0, tx_payload=0, credits=ENTRY_NUM, cred_err=0; FIFO empty, age 0.
- Latency: request accepted at edge t → tx_vld high in cycle after t (1 cycle), if credits > 0.
- Back-to-back: with tx_rdy=1 and credits available, one request per cycle sustained.
- cred_ret at edge t with credits 0 → tx_vld high in cycle after t.
- Promotion visible on tx_qos in the same cycle tx_vld rises if age reached threshold during the stall.
- Reset mid-operation: FIFO flushed, credits restored, in-flight presentation dropped immediately (async).

## Structure
- Shared package: QOS_W, QOS_MAX (all-ones), credit-width function; reused by the arbiter.
- One sub-module: sync_fifo (parameterised width/depth, registered count, full/empty outputs, head read combinational).
- Credit counter, age counter, promote mux live in qos_req_issuer.

## Test plan
- Reset, push qos=3 payload=0xA5 → next cycle tx_vld=1, tx_qos=3, tx_payload=0xA5; credits 32→31 on accept.
- Push 4 with tx_rdy=0 → src_rdy=0 after 4th; 5th src_vld held, not accepted; release tx_rdy → 4 pops in order, src_rdy=1 after first pop.
- Drain 32 credits → tx_vld=0 with head waiting; hold 16 cycles, then cred_ret → tx_vld=1, tx_qos=0xF, credits 0→1→0 on accept.
- Same-cycle cred_ret and tx handshake at credits=5 → credits remain 5.
- cred_ret at credits=32 → credits stay 32, cred_err=1 and stays 1 until rst_n.
- Assert rst_n=0 mid-stream with 3 queued and credits=10 → immediately tx_vld=0, credits=32, src_rdy=1; no stale request after release.
